ready_skid_buffer: RTL

Two-entry valid/ready pipeline stage that registers both directions of the handshake. `valid_out` and `data_out` come from flops. `ready_in` also comes from a flop, with no combinational path from `ready_out`. It is the backpressure-side complement to the single-entry forward-registered stage. It is used wherever a long `ready` path (e.g. dispatch → rename/fetch) must be cut without losing throughput. It also supports a synchronous `flush` for mispredict/exception recovery in the OoO pipeline.

---
 rtl/ready_skid_buffer.sv | 93 +++++++++
 1 files changed

// File: rtl/ready_skid_buffer.sv
// Two-entry valid/ready stage that registers both handshake directions.
// The main register drives data_out and the skid register catches the beat in flight when the consumer stalls.
module ready_skid_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [WIDTH-1:0] data_out,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             up, down;

  // Outputs decode registered state only, so ready_out never reaches ready_in.
  always_comb begin
    ready_in  = (state_q == EMPTY) || (state_q == ONE);
    valid_out = (state_q == ONE) || (state_q == FULL);
    data_out  = main_q;
    case (state_q)
      ONE:     count = 2'd1;
      FULL:    count = 2'd2;
      default: count = 2'd0;
    endcase
  end

  assign up   = valid_in && ready_in;
  assign down = valid_out && ready_out;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (up) begin
          state_d = ONE;
          main_d  = data_in;
        end
      end
      ONE: begin
        if (up && down) begin
          main_d = data_in;
        end else if (up) begin
          state_d = FULL;
          skid_d  = data_in;
        end else if (down) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (down) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // A flush drops every buffered beat and any beat accepted this cycle.
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule
